mult_req_sequencer: RTL and testbench
=====================================

// Module: mult_req_sequencer
// PURPOSE
//  Upstream driver for vdic_dut_2023: accepts operand pairs on a valid/ready stream and generates
//  even parity (optionally corrupted for error injection). Runs the req/ack handshake, then
//  captures result/result_rdy and checks result parity. Emits one status beat per operation on
//  an output valid/ready stream. A watchdog bounds each operation.
// PARAMETERS
//  ARG_W    16   operand width (signed)
//  RES_W    32   result width (2*ARG_W)
//  TIMEOUT  255  max cycles in REQ+WAIT before abort; counter width $clog2(TIMEOUT+1)
// PORTS
//  clk               in   1      single clock, all logic on posedge
//  rst_n             in   1      synchronous, active-low reset
//  in_valid          in   1      operand beat valid
//  in_ready          out  1      sequencer can accept a beat
//  in_a, in_b        in   ARG_W  signed operands
//  in_inj_a, in_inj_b in  1      1 = invert generated parity of a / b
//  arg_a, arg_b      out  ARG_W  to DUT
//  arg_a_parity      out  1      to DUT, ^arg_a ^ inj_a
//  arg_b_parity      out  1      to DUT, ^arg_b ^ inj_b
//  req               out  1      to DUT
//  ack               in   1      from DUT
//  result            in   RES_W  from DUT
//  result_parity     in   1      from DUT
//  result_rdy        in   1      from DUT, 1-cycle pulse
//  arg_parity_error  in   1      from DUT, qualified by result_rdy
//  res_valid         out  1      status beat valid
//  res_ready         in   1      downstream accepts beat
//  res_data          out  RES_W  captured result (0 on timeout)
//  res_par_err       out  1      DUT reported arg_parity_error
//  res_chk_err       out  1      ^result != result_parity (forced 0 if res_par_err or timeout)
//  res_timeout       out  1      watchdog expired
//  stray_evt         out  1      1-cycle pulse: ack or result_rdy seen in IDLE/OUT
// BEHAVIOUR
//  - Registered outputs, all 0 while rst_n=0. State IDLE. in_ready goes to 1 on the first edge
//    after release. Reset mid-operation drops req next edge and discards the transaction; no beat.
//  - IDLE: in_ready=1; in_valid&in_ready -> latch a,b and parities, in_ready=0, req=1 next cycle,
//    state REQ, timer cleared.
//  - REQ: req, arg_*, parities held stable. ack sampled 1 -> req=0 next cycle, state WAIT.
//    result_rdy in the same cycle as ack -> captured, state OUT directly.
//  - WAIT: result_rdy=1 -> capture result, result_parity, arg_parity_error -> state OUT.
//  - Watchdog: increments every cycle in REQ/WAIT. When it reaches TIMEOUT -> req=0, res_timeout=1,
//    res_data=0, state OUT. A result_rdy in the expiry cycle wins over the timeout.
//  - OUT: res_valid=1, res_* held stable until res_ready; on res_valid&res_ready -> IDLE and
//    in_ready=1 next cycle. Throughput: at most one op per 4 cycles with DUT ack on the 1st req
//    cycle plus DUT latency.
//  - ack/result_rdy in IDLE or OUT: ignored, stray_evt pulses for 1 cycle. ack in WAIT is ignored.
//  - Parity is even: p = ^vector. Results are not sign-modified; res_data is result verbatim.
// STRUCTURE
//  - mult_seq_pkg: ARG_W/RES_W defaults, state_t enum {IDLE,REQ,WAIT,OUT}, function even_par().
//  - Sub-module seq_wdog_timer (clear, enable, expired; parameter TIMEOUT). Rest is a single FSM.
// TESTING
//  1 a=3,b=5,no inj; DUT ack then result_rdy -> arg_a_parity=0, arg_b_parity=0, one beat
//    res_data=32'h0000000F, all err flags 0.
//  2 a=16'h8000,b=16'h0002,inj_a=1 -> arg_a_parity=0 (inverted); DUT flags arg_parity_error
//    -> res_par_err=1, res_chk_err=0.
//  3 DUT model flips result_parity for a=7,b=7 -> res_data=49, res_chk_err=1.
//  4 DUT never acks, TIMEOUT=255 -> req falls 255 cycles after rising; res_timeout=1, res_data=0.
//  5 res_ready held 0 for 10 cycles -> res_* stable, in_ready=0 throughout; then back-to-back ops
//    -> each input accepted exactly once, results in order.
//  6 rst_n=0 for 1 cycle while in WAIT -> req=0, res_valid=0, no beat emitted; ack in IDLE
//    -> stray_evt=1 for 1 cycle.

Source files
------------

// File: rtl/mult_req_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mult_req_sequencer_pkg
//   Shared definitions for the request sequencer that drives the vdic_dut_2023
//   multiplier: default widths, the sequencer state encoding and the even
//   parity helper used for operands and results.
// -----------------------------------------------------------------------------
package mult_req_sequencer_pkg;

   localparam int ARG_W_DEF = 16;
   localparam int RES_W_DEF = 32;

   // Widest vector even_par() accepts. Callers zero-extend narrower vectors,
   // which leaves the parity unchanged.
   localparam int PAR_W = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      OUT  = 2'd3
   } state_t;

   // Even parity: the bit that makes the total number of ones even.
   function automatic logic even_par(input logic [PAR_W-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/mult_req_sequencer_if.sv
// -----------------------------------------------------------------------------
// mult_req_sequencer_if
//   Bundles the three signal groups around the sequencer:
//     - operand stream   : in_valid/in_ready, in_a, in_b, in_inj_a, in_inj_b
//     - multiplier side  : arg_a/arg_b + parities, req/ack, result,
//                          result_parity, result_rdy, arg_parity_error
//     - status stream    : res_valid/res_ready, res_data, res_par_err,
//                          res_chk_err, res_timeout, plus the stray_evt pulse
//   master : the sequencer's view
//   slave  : the environment's view (operand source, multiplier, sink)
// -----------------------------------------------------------------------------
interface mult_req_sequencer_if
   import mult_req_sequencer_pkg::*;
#(
   parameter int ARG_W = ARG_W_DEF,
   parameter int RES_W = RES_W_DEF
);

   // operand stream
   logic                    in_valid;
   logic                    in_ready;
   logic signed [ARG_W-1:0] in_a;
   logic signed [ARG_W-1:0] in_b;
   logic                    in_inj_a;
   logic                    in_inj_b;

   // multiplier side
   logic signed [ARG_W-1:0] arg_a;
   logic signed [ARG_W-1:0] arg_b;
   logic                    arg_a_parity;
   logic                    arg_b_parity;
   logic                    req;
   logic                    ack;
   logic [RES_W-1:0]        result;
   logic                    result_parity;
   logic                    result_rdy;
   logic                    arg_parity_error;

   // status stream
   logic                    res_valid;
   logic                    res_ready;
   logic [RES_W-1:0]        res_data;
   logic                    res_par_err;
   logic                    res_chk_err;
   logic                    res_timeout;
   logic                    stray_evt;

   modport master (
      input  in_valid, in_a, in_b, in_inj_a, in_inj_b,
      input  ack, result, result_parity, result_rdy, arg_parity_error,
      input  res_ready,
      output in_ready,
      output arg_a, arg_b, arg_a_parity, arg_b_parity, req,
      output res_valid, res_data, res_par_err, res_chk_err, res_timeout,
      output stray_evt
   );

   modport slave (
      output in_valid, in_a, in_b, in_inj_a, in_inj_b,
      output ack, result, result_parity, result_rdy, arg_parity_error,
      output res_ready,
      input  in_ready,
      input  arg_a, arg_b, arg_a_parity, arg_b_parity, req,
      input  res_valid, res_data, res_par_err, res_chk_err, res_timeout,
      input  stray_evt
   );

endinterface

// File: rtl/seq_wdog_timer.sv
// -----------------------------------------------------------------------------
// seq_wdog_timer
//   Per-operation watchdog. Counts enabled cycles since the last clear and
//   flags the cycle in which the count reaches TIMEOUT, so an operation that
//   has spent TIMEOUT cycles in the request/wait phase is aborted at the edge
//   that closes its TIMEOUT-th cycle.
// Ports
//   clk        in   clock, posedge
//   rst_n      in   synchronous active-low reset
//   clear_i    in   restart the count from zero (has priority over enable_i)
//   enable_i   in   count this cycle
//   expired_o  out  this enabled cycle is the TIMEOUT-th one (combinational)
// -----------------------------------------------------------------------------
module seq_wdog_timer #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int            CW    = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] TOP   = CW'(TIMEOUT);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Saturate at TOP so a stalled enable can never wrap and re-fire.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i && (cnt_q != TOP)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // cnt_q holds the number of already completed enabled cycles, so the
   // TIMEOUT-th cycle is the one where cnt_q == TIMEOUT-1.
   assign expired_o = enable_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/mult_req_sequencer.sv
// -----------------------------------------------------------------------------
// mult_req_sequencer
//   Upstream driver for the vdic_dut_2023 multiplier. Takes one operand pair
//   per transfer on the operand stream, generates even parity for each operand
//   (optionally inverted for error injection), runs the req/ack handshake,
//   captures result/result_parity/arg_parity_error on the result_rdy pulse,
//   checks result parity and emits one status beat per operation. A watchdog
//   aborts an operation that stays in REQ/WAIT for TIMEOUT cycles.
// Ports
//   clk    in   clock, all logic on posedge
//   rst_n  in   synchronous active-low reset; every output is 0 while low
//   bus    --   mult_req_sequencer_if.master:
//                 in_valid/in_ready/in_a/in_b/in_inj_a/in_inj_b   operand stream
//                 arg_a/arg_b/arg_*_parity/req -> multiplier
//                 ack/result/result_parity/result_rdy/arg_parity_error <- multiplier
//                 res_valid/res_ready/res_data/res_par_err/res_chk_err/res_timeout
//                                                               status stream
//                 stray_evt  1-cycle pulse on ack/result_rdy while idle or
//                            presenting a status beat
// Parameters
//   ARG_W    operand width (signed)
//   RES_W    result width (2*ARG_W)
//   TIMEOUT  REQ+WAIT cycle budget per operation
// -----------------------------------------------------------------------------
module mult_req_sequencer
   import mult_req_sequencer_pkg::*;
#(
   parameter int ARG_W   = ARG_W_DEF,
   parameter int RES_W   = RES_W_DEF,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   mult_req_sequencer_if.master bus
);

   state_t                  state_q;
   logic                    in_ready_q;
   logic                    req_q;
   logic signed [ARG_W-1:0] arg_a_q;
   logic signed [ARG_W-1:0] arg_b_q;
   logic                    arg_a_par_q;
   logic                    arg_b_par_q;
   logic                    res_valid_q;
   logic [RES_W-1:0]        res_data_q;
   logic                    res_par_err_q;
   logic                    res_chk_err_q;
   logic                    res_timeout_q;
   logic                    stray_q;

   logic                    wd_clear;
   logic                    wd_enable;
   logic                    wd_expired;
   logic                    in_par_a;
   logic                    in_par_b;
   logic                    res_par_calc;

   // The watchdog runs only while an operation is outstanding and restarts
   // from zero whenever the sequencer sits idle.
   assign wd_enable = (state_q == REQ) || (state_q == WAIT);
   assign wd_clear  = (state_q == IDLE);

   seq_wdog_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (wd_clear),
      .enable_i  (wd_enable),
      .expired_o (wd_expired)
   );

   // Operands are parity-checked as raw bit patterns, hence the unsigned
   // zero-extension into the parity helper.
   assign in_par_a     = even_par(PAR_W'($unsigned(bus.in_a)));
   assign in_par_b     = even_par(PAR_W'($unsigned(bus.in_b)));
   assign res_par_calc = even_par(PAR_W'(bus.result));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         in_ready_q    <= 1'b0;
         req_q         <= 1'b0;
         arg_a_q       <= '0;
         arg_b_q       <= '0;
         arg_a_par_q   <= 1'b0;
         arg_b_par_q   <= 1'b0;
         res_valid_q   <= 1'b0;
         res_data_q    <= '0;
         res_par_err_q <= 1'b0;
         res_chk_err_q <= 1'b0;
         res_timeout_q <= 1'b0;
         stray_q       <= 1'b0;
      end else begin
         stray_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               stray_q <= bus.ack || bus.result_rdy;
               if (bus.in_valid && in_ready_q) begin
                  arg_a_q     <= bus.in_a;
                  arg_b_q     <= bus.in_b;
                  arg_a_par_q <= in_par_a ^ bus.in_inj_a;
                  arg_b_par_q <= in_par_b ^ bus.in_inj_b;
                  in_ready_q  <= 1'b0;
                  req_q       <= 1'b1;
                  state_q     <= REQ;
               end else begin
                  // Also the path that raises in_ready on the first edge
                  // after reset release.
                  in_ready_q <= 1'b1;
               end
            end

            // result_rdy outranks both the watchdog and ack: a result that
            // arrives in the expiry cycle is still delivered, and a result
            // together with ack skips WAIT.
            REQ: begin
               if (bus.result_rdy) begin
                  req_q         <= 1'b0;
                  res_valid_q   <= 1'b1;
                  res_data_q    <= bus.result;
                  res_par_err_q <= bus.arg_parity_error;
                  res_chk_err_q <= !bus.arg_parity_error &&
                                   (res_par_calc != bus.result_parity);
                  res_timeout_q <= 1'b0;
                  state_q       <= OUT;
               end else if (wd_expired) begin
                  req_q         <= 1'b0;
                  res_valid_q   <= 1'b1;
                  res_data_q    <= '0;
                  res_par_err_q <= 1'b0;
                  res_chk_err_q <= 1'b0;
                  res_timeout_q <= 1'b1;
                  state_q       <= OUT;
               end else if (bus.ack) begin
                  req_q   <= 1'b0;
                  state_q <= WAIT;
               end
            end

            // ack is meaningless here and deliberately ignored.
            WAIT: begin
               if (bus.result_rdy) begin
                  res_valid_q   <= 1'b1;
                  res_data_q    <= bus.result;
                  res_par_err_q <= bus.arg_parity_error;
                  res_chk_err_q <= !bus.arg_parity_error &&
                                   (res_par_calc != bus.result_parity);
                  res_timeout_q <= 1'b0;
                  state_q       <= OUT;
               end else if (wd_expired) begin
                  res_valid_q   <= 1'b1;
                  res_data_q    <= '0;
                  res_par_err_q <= 1'b0;
                  res_chk_err_q <= 1'b0;
                  res_timeout_q <= 1'b1;
                  state_q       <= OUT;
               end
            end

            // Status fields stay frozen until the sink takes the beat.
            OUT: begin
               stray_q <= bus.ack || bus.result_rdy;
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready     = in_ready_q;
   assign bus.req          = req_q;
   assign bus.arg_a        = arg_a_q;
   assign bus.arg_b        = arg_b_q;
   assign bus.arg_a_parity = arg_a_par_q;
   assign bus.arg_b_parity = arg_b_par_q;
   assign bus.res_valid    = res_valid_q;
   assign bus.res_data     = res_data_q;
   assign bus.res_par_err  = res_par_err_q;
   assign bus.res_chk_err  = res_chk_err_q;
   assign bus.res_timeout  = res_timeout_q;
   assign bus.stray_evt    = stray_q;

endmodule

// File: tb/tb_mult_req_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mult_req_sequencer
//   Directed bench for mult_req_sequencer. The initial block plays operand
//   source, multiplier and (through res_ready) sink; expected status beats are
//   queued when an operation is issued and compared by a monitor when the
//   sequencer hands a beat over.
// -----------------------------------------------------------------------------
module tb_mult_req_sequencer;

   localparam int AW = 16;
   localparam int RW = 32;
   localparam int TO = 255;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   mult_req_sequencer_if #(.ARG_W(AW), .RES_W(RW)) bus ();

   mult_req_sequencer #(
      .ARG_W   (AW),
      .RES_W   (RW),
      .TIMEOUT (TO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic [RW-1:0] data;
      logic          par;
      logic          chk;
      logic          tmo;
   } beat_t;

   beat_t sb[$];
   beat_t exp_beat;
   beat_t got_beat;
   int    n_cmp = 0;
   int    n_bad = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [RW-1:0] prod(input logic signed [AW-1:0] a, input logic signed [AW-1:0] b);
      logic signed [RW-1:0] x;
      logic signed [RW-1:0] y;
      x = a;
      y = b;
      return x * y;
   endfunction

   // Scoreboard side: a beat is transferred at the posedge following a
   // negedge that shows res_valid && res_ready.
   always @(negedge clk) begin
      if (rst_n && bus.res_valid && bus.res_ready) begin
         if (sb.size() == 0) begin
            check("beat_expected", 64'(sb.size() != 0), 64'(1));
         end else begin
            exp_beat = sb.pop_front();
            got_beat = {bus.res_data, bus.res_par_err, bus.res_chk_err, bus.res_timeout};
            check("beat", 64'(got_beat), 64'(exp_beat));
         end
      end
   end

   // Multiplier model: answers from what it sees on the arg pins.
   task automatic drive_result(input logic flip, input logic with_ack);
      logic [RW-1:0] r;
      r = prod(bus.arg_a, bus.arg_b);
      bus.result           = r;
      bus.result_parity    = (^r) ^ flip;
      bus.arg_parity_error = (bus.arg_a_parity != ^bus.arg_a) || (bus.arg_b_parity != ^bus.arg_b);
      bus.result_rdy       = 1'b1;
      bus.ack              = with_ack;
      @(negedge clk);
      bus.result_rdy = 1'b0;
      bus.ack        = 1'b0;
   endtask

   task automatic put_beat(input logic signed [AW-1:0] a, input logic signed [AW-1:0] b,
                           input logic ia, input logic ib);
      int n;
      n = 0;
      @(negedge clk);
      while (bus.in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", 64'(bus.in_ready), 64'(1));
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_inj_a = ia;
      bus.in_inj_b = ib;
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_req();
      int n;
      n = 0;
      while (bus.req !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("req_rise", 64'(bus.req), 64'(1));
   endtask

   task automatic pulse_ack();
      bus.ack = 1'b1;
      @(negedge clk);
      bus.ack = 1'b0;
      check("req_drop_on_ack", 64'(bus.req), 64'(0));
   endtask

   task automatic run_op(input logic signed [AW-1:0] a, input logic signed [AW-1:0] b,
                         input logic ia, input logic ib, input logic flip,
                         input int ack_dly, input int rdy_dly, input logic together);
      sb.push_back('{data: prod(a, b), par: ia | ib, chk: !(ia | ib) && flip, tmo: 1'b0});
      put_beat(a, b, ia, ib);
      wait_req();
      check("arg_a", 64'($unsigned(bus.arg_a)), 64'($unsigned(a)));
      check("arg_b", 64'($unsigned(bus.arg_b)), 64'($unsigned(b)));
      check("arg_a_parity", 64'(bus.arg_a_parity), 64'((^a) ^ ia));
      check("arg_b_parity", 64'(bus.arg_b_parity), 64'((^b) ^ ib));
      check("in_ready_busy", 64'(bus.in_ready), 64'(0));
      if (together) begin
         drive_result(flip, 1'b1);
         check("req_drop_on_rdy", 64'(bus.req), 64'(0));
      end else begin
         repeat (ack_dly) @(negedge clk);
         pulse_ack();
         repeat (rdy_dly) @(negedge clk);
         drive_result(flip, 1'b0);
      end
   endtask

   initial begin
      int n;
      logic [RW-1:0] held;

      bus.in_valid = 1'b0;  bus.in_a = '0;  bus.in_b = '0;
      bus.in_inj_a = 1'b0;  bus.in_inj_b = 1'b0;
      bus.ack = 1'b0;       bus.result = '0;  bus.result_parity = 1'b0;
      bus.result_rdy = 1'b0; bus.arg_parity_error = 1'b0;
      bus.res_ready = 1'b1;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 64'(bus.in_ready), 64'(0));
      check("rst_req", 64'(bus.req), 64'(0));
      check("rst_res_valid", 64'(bus.res_valid), 64'(0));
      check("rst_stray", 64'(bus.stray_evt), 64'(0));
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("in_ready_before_edge", 64'(bus.in_ready), 64'(0));
      @(negedge clk);
      check("in_ready_after_edge", 64'(bus.in_ready), 64'(1));

      // 1: plain multiply
      run_op(16'sd3, 16'sd5, 1'b0, 1'b0, 1'b0, 1, 2, 1'b0);
      // 2: injected parity on a, multiplier reports arg_parity_error
      run_op(16'sh8000, 16'sh0002, 1'b1, 1'b0, 1'b0, 0, 1, 1'b0);
      // 3: multiplier corrupts result parity
      run_op(16'sd7, 16'sd7, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);

      // 4: no ack -> watchdog abort exactly TO cycles after req rises
      sb.push_back('{data: '0, par: 1'b0, chk: 1'b0, tmo: 1'b1});
      put_beat(16'sd1, 16'sd2, 1'b0, 1'b0);
      wait_req();
      n = 0;
      while (bus.req === 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("timeout_req_cycles", 64'(n), 64'(TO));

      // 4b: result_rdy in the expiry cycle beats the watchdog
      sb.push_back('{data: prod(-16'sd2, 16'sd9), par: 1'b0, chk: 1'b0, tmo: 1'b0});
      put_beat(-16'sd2, 16'sd9, 1'b0, 1'b0);
      wait_req();
      repeat (TO - 1) @(negedge clk);
      drive_result(1'b0, 1'b0);
      check("expiry_rdy_req", 64'(bus.req), 64'(0));

      // 5: back-pressure on the status stream
      @(negedge clk);
      @(posedge clk); #1 bus.res_ready = 1'b0;
      run_op(-16'sd3, 16'sd100, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
      check("bp_valid", 64'(bus.res_valid), 64'(1));
      held = bus.res_data;
      check("bp_data", 64'(held), 64'(prod(-16'sd3, 16'sd100)));
      repeat (10) begin
         @(negedge clk);
         check("bp_hold_valid", 64'(bus.res_valid), 64'(1));
         check("bp_hold_data", 64'(bus.res_data), 64'(prod(-16'sd3, 16'sd100)));
         check("bp_in_ready", 64'(bus.in_ready), 64'(0));
      end
      @(posedge clk); #1 bus.res_ready = 1'b1;

      // back-to-back operations, immediate ack, one with ack+result together
      run_op(16'sd12, -16'sd12, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
      run_op(16'sh7fff, 16'sh7fff, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
      run_op(-16'sd1, -16'sd1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
      run_op(16'sd0, 16'sd1234, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);

      // 6: reset while waiting for the result discards the operation
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      put_beat(16'sd11, 16'sd12, 1'b0, 1'b0);
      wait_req();
      pulse_ack();
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("midrst_req", 64'(bus.req), 64'(0));
      check("midrst_res_valid", 64'(bus.res_valid), 64'(0));
      check("midrst_in_ready", 64'(bus.in_ready), 64'(0));
      @(negedge clk);
      check("midrst_in_ready_back", 64'(bus.in_ready), 64'(1));
      bus.ack = 1'b1;
      @(negedge clk);
      bus.ack = 1'b0;
      check("stray_pulse", 64'(bus.stray_evt), 64'(1));
      check("stray_no_req", 64'(bus.req), 64'(0));
      @(negedge clk);
      check("stray_cleared", 64'(bus.stray_evt), 64'(0));
      repeat (5) @(negedge clk);
      check("no_beat_after_rst", 64'(bus.res_valid), 64'(0));

      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("sb_drained", 64'(sb.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
